// File: rtl/fifo_read_stream_if.sv
// ============================================================================
// Module      : fifo_read_stream_if
// Description : Bundles the FIFO read side and the output stream of
//               fifo_read_stream.
//               master : the stream block (drives rd_en, out_*, busy, xfer_cnt)
//               slave  : the environment (drives en, empty, read_data,
//                        out_ready)
// Signals     : en, empty, read_data, rd_en, out_valid, out_ready, out_data,
//               busy, xfer_cnt
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_read_stream_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  en;
   logic                  empty;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  rd_en;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  xfer_cnt;

   modport master (
      input  en, empty, read_data, out_ready,
      output rd_en, out_valid, out_data, busy, xfer_cnt
   );

   modport slave (
      output en, empty, read_data, out_ready,
      input  rd_en, out_valid, out_data, busy, xfer_cnt
   );
endinterface

`default_nettype wire

// File: rtl/fifo_read_stream.sv
// ============================================================================
// Module      : fifo_read_stream
// Description : Pulls words from a FIFO read port that has one cycle of read
//               latency. The words go out on a valid/ready stream through a
//               2-entry in-order skid buffer. rd_en is only issued when the
//               buffered word, plus the word in flight, minus the word being
//               popped this cycle, leaves a free slot. The buffer can
//               therefore never overflow.
// Ports       : rd_clk - clock, all state on rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - fifo_read_stream_if.master
//                        (en/empty/read_data/rd_en on the FIFO side,
//                        out_valid/out_ready/out_data on the stream side,
//                        busy, xfer_cnt)
// Options     : FIFO_RD_STATS_EN - when defined, xfer_cnt counts accepted
//               words and saturates at all-ones. When undefined, xfer_cnt is
//               tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  wire logic           rd_clk,
   input  wire logic           rst_n,
   fifo_read_stream_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [1:0]            r_occ;        // buffered words, 0..2
   logic                  r_infl;       // rd_en was issued last cycle
   logic [DATA_WIDTH-1:0] r_buf0;       // head, drives out_data directly
   logic [DATA_WIDTH-1:0] r_buf1;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_rd_en;
   logic [2:0]            w_level;
   logic [1:0]            w_occ_nxt;
   logic [DATA_WIDTH-1:0] w_buf0_nxt;
   logic [DATA_WIDTH-1:0] w_buf1_nxt;

   assign w_pop  = (r_occ != 2'd0) & bus.out_ready;
   assign w_push = r_infl;

   // Occupancy after this edge if nothing new is requested. A pop implies
   // occ >= 1, so the subtraction cannot wrap.
   assign w_level = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};

   assign w_rd_en = (r_state == ST_RUN) & ~bus.empty & (w_level < 3'd2);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.en) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.en) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // A renewed run request takes priority over finishing the drain
            if (bus.en)
               w_state_nxt = ST_RUN;
            else if (!r_infl && (r_occ == 2'd0))
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Skid buffer update. The in-flight word always lands at the tail.
   // A pop shifts entry 1 into the head.
   // ------------------------------------------------------------------
   always_comb begin
      w_occ_nxt  = r_occ;
      w_buf0_nxt = r_buf0;
      w_buf1_nxt = r_buf1;
      case ({w_push, w_pop})
         2'b01: begin
            w_buf0_nxt = r_buf1;
            w_occ_nxt  = r_occ - 2'd1;
         end
         2'b10: begin
            if (r_occ == 2'd0)
               w_buf0_nxt = bus.read_data;
            else
               w_buf1_nxt = bus.read_data;
            w_occ_nxt = r_occ + 2'd1;
         end
         2'b11: begin
            // Occupancy is unchanged. The new word goes behind whatever
            // word is still buffered.
            if (r_occ == 2'd1) begin
               w_buf0_nxt = bus.read_data;
            end else begin
               w_buf0_nxt = r_buf1;
               w_buf1_nxt = bus.read_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_occ   <= 2'd0;
         r_infl  <= 1'b0;
         r_buf0  <= '0;
         r_buf1  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_occ   <= w_occ_nxt;
         r_infl  <= w_rd_en;
         r_buf0  <= w_buf0_nxt;
         r_buf1  <= w_buf1_nxt;
      end
   end

   assign bus.rd_en     = w_rd_en;
   assign bus.out_valid = (r_occ != 2'd0);
   assign bus.out_data  = r_buf0;
   assign bus.busy      = (r_state != ST_IDLE);

   // ------------------------------------------------------------------
   // Accepted-word counter
   // ------------------------------------------------------------------
`ifdef FIFO_RD_STATS_EN
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] r_xfer_cnt;

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n)
         r_xfer_cnt <= '0;
      else if (w_pop && (r_xfer_cnt != {CNT_WIDTH{1'b1}}))
         r_xfer_cnt <= r_xfer_cnt + c_CNT_ONE;
   end

   assign bus.xfer_cnt = r_xfer_cnt;
`else
   assign bus.xfer_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_stream.sv
// ============================================================================
// Module      : tb_fifo_read_stream
// Description : Self-checking bench for fifo_read_stream. A queue models the
//               FIFO, including its one-cycle read latency. A second queue
//               holds the words taken from the FIFO and not yet delivered. It
//               serves as the ordering scoreboard. out_valid is predicted
//               from word counts: a word is visible two edges after its
//               rd_en. A cycle table covers the basic stream, followed by
//               directed stall, drain, reset and empty sequences and a
//               randomized run.
//               CNT_WIDTH is reduced to 4 so that counter saturation is
//               reached. Honours FIFO_RD_STATS_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_read_stream;

   localparam int c_DW = 8;
   localparam int c_CW = 4;
   localparam int c_CNT_MAX = (1 << c_CW) - 1;

   logic rd_clk = 1'b0;
   logic rst_n  = 1'b1;

   fifo_read_stream_if #(.DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW)) bus ();

   fifo_read_stream #(.DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW)) dut (
      .rd_clk (rd_clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 rd_clk = ~rd_clk;

   typedef struct {
      logic            en;
      logic            ready;
      logic            rd_en;
      logic            ov;
      logic [c_DW-1:0] od;
   } vec_t;

   int              checks = 0;
   int              errors = 0;
   logic [c_DW-1:0] fifo_q[$];
   logic [c_DW-1:0] exp_q[$];
   int              landed, accepts, total_in;
   bit              pending_land, stalled;
   logic [c_DW-1:0] stall_data;
   logic            s_rd_en, s_ov, s_busy, s_ready;
   logic [c_DW-1:0] s_od;
   logic [c_CW-1:0] s_cnt;
   vec_t            tbl[12];
   logic [c_DW-1:0] words[8];
   logic            pat[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef FIFO_RD_STATS_EN
      return (accepts > c_CNT_MAX) ? c_CNT_MAX : accepts;
`else
      return 0;
`endif
   endfunction

   // Called just after a falling edge, with the inputs already set.
   // Samples the outputs, checks them, advances one rising edge, updates
   // the FIFO and the model, and returns on the next falling edge.
   task automatic cycle();
      #1;
      s_rd_en = bus.rd_en;
      s_ov    = bus.out_valid;
      s_od    = bus.out_data;
      s_busy  = bus.busy;
      s_cnt   = bus.xfer_cnt;
      s_ready = bus.out_ready;
      if (s_rd_en) check("rd_en_while_empty", bus.empty, 0);
      check("out_valid", s_ov, landed > accepts);
      if (s_ov && exp_q.size() > 0) check("out_data_order", s_od, exp_q[0]);
      if (stalled) begin
         check("stall_valid", s_ov, 1);
         check("stall_data", s_od, stall_data);
      end
      check("xfer_cnt", s_cnt, exp_cnt());
      @(posedge rd_clk);
      #1;
      if (pending_land) landed++;
      pending_land = s_rd_en;
      if (s_ov && s_ready) begin
         accepts++;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (s_rd_en && fifo_q.size() > 0) begin
         bus.read_data = fifo_q.pop_front();
         exp_q.push_back(bus.read_data);
      end
      check("occ_plus_infl_le2", exp_q.size() <= 2, 1);
      stalled    = s_ov && !s_ready;
      stall_data = s_od;
      bus.empty  = (fifo_q.size() == 0);
      @(negedge rd_clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_xfer_cnt", bus.xfer_cnt, 0);
      exp_q.delete();
      landed = 0; accepts = 0; pending_land = 0; stalled = 0;
      @(negedge rd_clk);
      @(negedge rd_clk);
      rst_n = 1'b1;
   endtask

   task automatic load_words();
      fifo_q.delete();
      for (int i = 0; i < 8; i++) fifo_q.push_back(words[i]);
      bus.empty = 1'b0;
   endtask

   initial begin
      words = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 12; c++) begin
         tbl[c].en    = 1'b1;
         tbl[c].ready = 1'b1;
         tbl[c].rd_en = (c >= 1 && c <= 8);
         tbl[c].ov    = (c >= 3 && c <= 10);
         tbl[c].od    = (c >= 3 && c <= 10) ? words[c-3] : '0;
      end
      bus.en = 1'b0; bus.out_ready = 1'b0; bus.read_data = '0; bus.empty = 1'b1;
      landed = 0; accepts = 0; total_in = 0; pending_land = 0; stalled = 0;
      @(negedge rd_clk);

      // Basic stream: one word per cycle, 2-cycle latency
      do_reset();
      load_words();
      for (int c = 0; c < 12; c++) begin
         bus.en = tbl[c].en;
         bus.out_ready = tbl[c].ready;
         cycle();
         check($sformatf("tbl_rd_en_c%0d", c), s_rd_en, tbl[c].rd_en);
         check($sformatf("tbl_valid_c%0d", c), s_ov, tbl[c].ov);
         if (tbl[c].ov) check($sformatf("tbl_data_c%0d", c), s_od, tbl[c].od);
      end
      check("stream_cnt_end", bus.xfer_cnt, exp_cnt());
      check("stream_accepts", accepts, 8);

      // Stall pattern 1,0,0,1
      do_reset();
      load_words();
      bus.en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.out_ready = pat[i % 4];
         cycle();
      end
      check("stall_accepts", accepts, 8);
      check("stall_fifo_left", fifo_q.size(), 0);

      // Drop en in the cycle of the third FIFO pop, then drain
      do_reset();
      load_words();
      bus.en = 1'b1; bus.out_ready = 1'b1;
      cycle(); cycle(); cycle();
      bus.en = 1'b0;
      cycle();
      check("drain_third_pop", s_rd_en, 1);
      cycle();
      check("drain_rd_en_off", s_rd_en, 0);
      check("drain_busy", s_busy, 1);
      begin
         int n;
         n = 0;
         while (bus.busy && n < 20) begin
            cycle();
            check("drain_no_rd_en", s_rd_en, 0);
            n++;
         end
         check("drain_reached_idle", bus.busy, 0);
      end
      check("drain_delivered", accepts, 3);
      check("drain_fifo_left", fifo_q.size(), 5);

      // Reset with a word buffered and a word in flight
      bus.en = 1'b1; bus.out_ready = 1'b0;
      cycle(); cycle(); cycle();
      check("pre_rst_valid", bus.out_valid, 1);
      check("pre_rst_cnt", bus.xfer_cnt, exp_cnt());
      bus.en = 1'b0;
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("post_rst_rd_en", s_rd_en, 0);
         check("post_rst_valid", s_ov, 0);
      end
      check("post_rst_fifo_left", fifo_q.size(), 3);

      // FIFO empty throughout
      do_reset();
      fifo_q.delete();
      bus.empty = 1'b1; bus.en = 1'b1;
      cycle();
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("empty_rd_en", s_rd_en, 0);
         check("empty_busy", s_busy, 1);
      end

      // Randomized traffic
      do_reset();
      total_in = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) begin
            fifo_q.push_back(c_DW'($urandom));
            total_in++;
         end
         bus.empty     = (fifo_q.size() == 0);
         bus.en        = ($urandom_range(0, 9) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      bus.en = 1'b1; bus.out_ready = 1'b1;
      begin
         int n;
         n = 0;
         while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < 100) begin
            cycle();
            n++;
         end
      end
      check("rand_all_delivered", accepts, total_in);
      check("rand_sat_cnt", bus.xfer_cnt, exp_cnt());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
